// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM state, mm:ss limits
// and the binary-to-BCD helper used for the display outputs.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAUSED,
        ST_RUN,
        ST_ALARM
    } state_t;

    localparam logic [5:0] MAX_MM      = 6'd59;
    localparam logic [5:0] MAX_SS      = 6'd59;
    localparam int         BCD_DIGIT_W = 4;

    // Two-digit BCD {tens, ones} of a 0..59 binary value.
    function automatic logic [2*BCD_DIGIT_W-1:0] to_bcd(input logic [5:0] v);
        return {BCD_DIGIT_W'(v / 6'd10), BCD_DIGIT_W'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for a divided clock, plus a registered one-cycle pulse
// on each rising edge of the synchronized level.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic s1_reg;
    logic s2_reg;
    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            s1_reg    <= din;
            s2_reg    <= s1_reg;
            prev_reg  <= s2_reg;
            pulse_reg <= s2_reg & ~prev_reg;
        end
    end

    assign level = s2_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with alarm phase. Define COUNTDOWN_TONE_EN to enable
// the gated 440 Hz buzzer output; otherwise tone_out is tied low.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int ALARM_SECS = 10
) (
    input  logic       inp_clk,
    input  logic       rst,
    input  logic       clk_1hz_in,
    input  logic       clk_440hz_in,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start_stop,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic       tone_out
);

    localparam logic [5:0] ALARM_INIT = 6'(ALARM_SECS);

    state_t     state_reg;
    logic [5:0] mm_reg;
    logic [5:0] ss_reg;
    logic [5:0] alarm_cnt_reg;
    logic [7:0] min_bcd_reg;
    logic [7:0] sec_bcd_reg;
    logic       running_reg;
    logic       alarm_reg;
    logic       tick;
    logic       sec_level_unused;
    logic [5:0] load_mm;
    logic [5:0] load_ss;

    edge_sync u_sync_1hz (
        .clk  (inp_clk),
        .rst  (rst),
        .din  (clk_1hz_in),
        .level(sec_level_unused),
        .pulse(tick)
    );

`ifdef COUNTDOWN_TONE_EN
    logic tone_level;
    logic tone_edge_unused;

    edge_sync u_sync_440hz (
        .clk  (inp_clk),
        .rst  (rst),
        .din  (clk_440hz_in),
        .level(tone_level),
        .pulse(tone_edge_unused)
    );

    assign tone_out = alarm_reg & tone_level;
`else
    logic tone_in_unused;
    assign tone_in_unused = clk_440hz_in;
    assign tone_out       = 1'b0;
`endif

    assign load_mm = (load_min > MAX_MM) ? MAX_MM : load_min;
    assign load_ss = (load_sec > MAX_SS) ? MAX_SS : load_sec;

    always_ff @(posedge inp_clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            mm_reg        <= 6'd0;
            ss_reg        <= 6'd0;
            alarm_cnt_reg <= 6'd0;
            running_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_PAUSED: begin
                    // load beats start_stop when both arrive together
                    if (load) begin
                        mm_reg    <= load_mm;
                        ss_reg    <= load_ss;
                        state_reg <= (load_mm != 6'd0 || load_ss != 6'd0) ? ST_PAUSED : ST_IDLE;
                    end else if (start_stop && state_reg == ST_PAUSED) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (mm_reg == 6'd0 && ss_reg <= 6'd1) begin
                            mm_reg        <= 6'd0;
                            ss_reg        <= 6'd0;
                            alarm_cnt_reg <= ALARM_INIT;
                            state_reg     <= ST_ALARM;
                            running_reg   <= 1'b0;
                            alarm_reg     <= 1'b1;
                        end else begin
                            if (ss_reg == 6'd0) begin
                                ss_reg <= MAX_SS;
                                mm_reg <= mm_reg - 6'd1;
                            end else begin
                                ss_reg <= ss_reg - 6'd1;
                            end
                            if (start_stop) begin
                                state_reg   <= ST_PAUSED;
                                running_reg <= 1'b0;
                            end
                        end
                    end else if (start_stop) begin
                        state_reg   <= ST_PAUSED;
                        running_reg <= 1'b0;
                    end
                end
                ST_ALARM: begin
                    if (start_stop) begin
                        mm_reg        <= 6'd0;
                        ss_reg        <= 6'd0;
                        alarm_cnt_reg <= 6'd0;
                        state_reg     <= ST_IDLE;
                        alarm_reg     <= 1'b0;
                    end else if (tick) begin
                        if (alarm_cnt_reg <= 6'd1) begin
                            alarm_cnt_reg <= 6'd0;
                            state_reg     <= ST_IDLE;
                            alarm_reg     <= 1'b0;
                        end else begin
                            alarm_cnt_reg <= alarm_cnt_reg - 6'd1;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    running_reg <= 1'b0;
                    alarm_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Display registers trail the count by one cycle.
    always_ff @(posedge inp_clk) begin
        if (!rst) begin
            min_bcd_reg <= 8'h00;
            sec_bcd_reg <= 8'h00;
        end else begin
            min_bcd_reg <= to_bcd(mm_reg);
            sec_bcd_reg <= to_bcd(ss_reg);
        end
    end

    assign min_bcd = min_bcd_reg;
    assign sec_bcd = sec_bcd_reg;
    assign running = running_reg;
    assign alarm   = alarm_reg;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter ALARM_SECS, default 10, meaning alarm duration in 1 Hz ticks (1..63).
REQ-002 SHALL have port inp_clk  input  1  system clock (100 MHz); single clock domain, all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port clk_1hz_in  input  1  divided 1 Hz square wave from the clock divider.
REQ-005 SHALL have port clk_440hz_in  input  1  divided 440 Hz square wave from the clock divider.
REQ-006 SHALL have port load  input  1  single-cycle pulse; load preset.
REQ-007 SHALL have port load_min  input  6  preset minutes, binary.
REQ-008 SHALL have port load_sec  input  6  preset seconds, binary.
REQ-009 SHALL have port start_stop  input  1  single-cycle pulse (debounced upstream).
REQ-010 SHALL have port min_bcd  output  8  minutes, two BCD digits {tens,ones}.
REQ-011 SHALL have port sec_bcd  output  8  seconds, two BCD digits {tens,ones}.
REQ-012 SHALL have port running  output  1  high in RUN.
REQ-013 SHALL have port alarm  output  1  high in ALARM.
REQ-014 SHALL have port tone_out  output  1  gated 440 Hz buzzer drive.

Function
REQ-015 SHALL pass clk_1hz_in and clk_440hz_in each through a 2-flop synchronizer; tick = sync2 & ~prev (one inp_clk cycle wide per rising edge).
REQ-016 SHALL assert tick exactly 3 inp_clk cycles after the first cycle clk_1hz_in is sampled high.
REQ-017 SHALL implement states IDLE, PAUSED, RUN, ALARM.
REQ-018 On load in IDLE or PAUSED: count <= {min(load_min,59), min(load_sec,59)}; next state PAUSED if result nonzero, else IDLE.
REQ-019 load in RUN or ALARM SHALL be ignored; load and start_stop in the same cycle in IDLE/PAUSED: load wins, start_stop ignored.
REQ-020 start_stop in PAUSED SHALL enter RUN; in IDLE SHALL be ignored; in RUN SHALL enter PAUSED; in ALARM SHALL clear count to 00:00 and enter IDLE.
REQ-021 In RUN, each tick SHALL decrement count by one second: ss>0 -> ss-1; ss=0 -> ss=59, mm-1; updated value visible on outputs the cycle after tick.
REQ-022 tick and start_stop in the same RUN cycle: decrement applied, then PAUSED (ALARM if decrement reaches 00:00).
REQ-023 Decrement reaching 00:00 SHALL enter ALARM and load alarm counter with ALARM_SECS.
REQ-024 In ALARM each tick SHALL decrement alarm counter; reaching 0 SHALL enter IDLE.
REQ-025 Ticks in IDLE/PAUSED SHALL be ignored; count never wraps below 00:00.
REQ-026 min_bcd/sec_bcd SHALL be registered BCD of count, updated one cycle after count changes.
REQ-027 tone_out SHALL equal synchronized clk_440hz_in while alarm=1, else 0.

Reset
REQ-028 While rst=0 at posedge: state IDLE, count 00:00, alarm counter 0, synchronizers 0, min_bcd=sec_bcd=8'h00, running=alarm=tone_out=0.
REQ-029 Reset mid-RUN or mid-ALARM SHALL abort immediately; no pending tick survives reset.

Configuration
REQ-030 Macro COUNTDOWN_TONE_EN defined: tone_out per REQ-027 and 440 Hz synchronizer present.
REQ-031 Macro COUNTDOWN_TONE_EN undefined: tone_out tied 0, 440 Hz synchronizer omitted; all other behaviour identical.

Structure
REQ-032 Shared package timer_pkg SHALL hold state enum, MAX_MM=59, MAX_SS=59 and BCD digit width.
REQ-033 Sub-module edge_sync (2-flop sync + rising-edge pulse) SHALL be instantiated per divided clock.

Verification
REQ-034 load_min=1, load_sec=2, load, start_stop, 3 ticks -> 01:01, 01:00, 00:59 then 00:59 held; running=1.
REQ-035 load 00:02, run, 2 ticks -> ALARM, alarm=1, tone_out follows 440 Hz; after 10 more ticks -> IDLE, alarm=0.
REQ-036 load_min=63, load_sec=45 -> min_bcd=8'h59, sec_bcd=8'h45; load 00:00 -> stays IDLE, start_stop ignored.
REQ-037 RUN at 00:10, start_stop same cycle as tick -> 00:09, PAUSED; further ticks -> no change.
REQ-038 rst=0 during ALARM at 00:00 -> next cycle all outputs 0, IDLE; load ignored during RUN leaves count unchanged.
